// File: rtl/bounce_counter_if.sv
// Control, bound and status signals of the bounded up/down counter.
interface bounce_counter_if #(
  parameter int WIDTH = 3
);
  logic             step;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             load_dir;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             hit;
  logic             cfg_err;

  modport master (
    output step, mode, lo, hi, load, load_val, load_dir,
    input  count, dir, hit, cfg_err
  );

  modport slave (
    input  step, mode, lo, hi, load, load_val, load_dir,
    output count, dir, hit, cfg_err
  );
endinterface

// File: rtl/bounce_counter.sv
// Bounded up/down counter: bounce, wrap-up, wrap-down or hold, with parallel load.
// Count, dir and hit update on the edge that samples step; cfg_err is combinational.
module bounce_counter #(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic            clock,
  input  logic            reset,
  bounce_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'b00,
    MODE_WRAP_UP   = 2'b01,
    MODE_WRAP_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             hit_q, hit_d;
  logic             cfg_err;
  logic             out_of_range;
  mode_e            mode;

  assign mode         = mode_e'(bus.mode);
  assign cfg_err      = (bus.lo > bus.hi);
  assign out_of_range = (count_q < bus.lo) || (count_q > bus.hi);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;

    if (bus.load) begin
      count_d = bus.load_val;
      dir_d   = bus.load_dir;
    end else if (!cfg_err && bus.step && (mode != MODE_HOLD)) begin
      if (out_of_range) begin
        count_d = bus.lo;
        dir_d   = 1'b0;
      end else if (bus.lo == bus.hi) begin
        count_d = bus.lo;
      end else begin
        // From here lo < hi and count is in range, so +/-1 never leaves the bounds.
        unique case (mode)
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (count_q == bus.hi) begin
                count_d = count_q - WIDTH'(1);
                dir_d   = 1'b1;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              if (count_q == bus.lo) begin
                count_d = count_q + WIDTH'(1);
                dir_d   = 1'b0;
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
          MODE_WRAP_UP: begin
            count_d = (count_q == bus.hi) ? bus.lo : count_q + WIDTH'(1);
            dir_d   = 1'b0;
          end
          MODE_WRAP_DOWN: begin
            count_d = (count_q == bus.lo) ? bus.hi : count_q - WIDTH'(1);
            dir_d   = 1'b1;
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
      hit_d = (count_d == bus.lo) || (count_d == bus.hi);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_VAL;
      dir_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.dir     = dir_q;
  assign bus.hit     = hit_q;
  assign bus.cfg_err = cfg_err;

endmodule

// File: tb/tb_bounce_counter.sv
// Directed and randomized checks of bounce_counter against a bounded-sweep reference model.
module tb_bounce_counter;

  localparam int W    = 3;
  localparam int RVAL = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_c = RVAL;
  int m_d = 0;
  int m_h = 0;

  bounce_counter_if #(.WIDTH(W)) bus ();

  bounce_counter #(.WIDTH(W), .RESET_VAL(W'(RVAL))) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sweep between lo and hi by reflection (bounce) or modular arithmetic (wrap).
  function automatic void model_step();
    int l, u, n, span;
    l = int'(bus.lo);
    u = int'(bus.hi);
    m_h = 0;
    if (bus.load) begin
      m_c = int'(bus.load_val);
      m_d = int'(bus.load_dir);
      return;
    end
    if (l > u || !bus.step || bus.mode == 2'b11) return;
    span = u - l + 1;
    if (m_c < l || m_c > u) begin
      m_c = l;
      m_d = 0;
    end else if (l == u) begin
      m_c = l;
    end else begin
      case (bus.mode)
        2'b00: begin
          n = m_c + ((m_d != 0) ? -1 : 1);
          if (n > u) begin n = u - 1; m_d = 1; end
          else if (n < l) begin n = l + 1; m_d = 0; end
          m_c = n;
        end
        2'b01: begin m_c = l + (m_c - l + 1) % span; m_d = 0; end
        default: begin m_c = l + (m_c - l - 1 + span) % span; m_d = 1; end
      endcase
    end
    m_h = (m_c == l || m_c == u) ? 1 : 0;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag);
    #1;
    chk({tag, "_cfg_err"}, 32'(bus.cfg_err), (bus.lo > bus.hi) ? 32'd1 : 32'd0);
    model_step();
    @(posedge clock);
    #1;
    chk({tag, "_count"}, 32'(bus.count), 32'(m_c));
    chk({tag, "_dir"},   32'(bus.dir),   32'(m_d));
    chk({tag, "_hit"},   32'(bus.hit),   32'(m_h));
    @(negedge clock);
  endtask

  task automatic set_cfg(input int l, input int u, input int md);
    bus.lo   = W'(l);
    bus.hi   = W'(u);
    bus.mode = 2'(md);
  endtask

  int exp1 [20] = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2,3,4,5,6};
  int exp2 [6]  = '{2,3,4,5,2,3};
  int exp3 [4]  = '{3,2,5,4};

  initial begin
    bus.step = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.load_dir = 1'b0;
    set_cfg(0, 7, 0);

    #12;
    chk("reset_count", 32'(bus.count), 32'(RVAL));
    chk("reset_dir",   32'(bus.dir),   32'd0);
    chk("reset_hit",   32'(bus.hit),   32'd0);
    @(negedge clock);
    reset = 1'b1;

    // full bounce sweep 0..7..0
    bus.step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle("t1");
      chk("t1_seq", 32'(bus.count), 32'(exp1[i]));
    end

    // wrap-up from 0 with lo=2, hi=5
    bus.step = 1'b0; bus.load = 1'b1; bus.load_val = '0; bus.load_dir = 1'b0;
    cycle("t2_load");
    bus.load = 1'b0; bus.step = 1'b1;
    set_cfg(2, 5, 1);
    for (int i = 0; i < 6; i++) begin
      cycle("t2");
      chk("t2_seq", 32'(bus.count), 32'(exp2[i]));
    end

    // wrap-down after loading 4
    set_cfg(2, 5, 2);
    bus.step = 1'b0; bus.load = 1'b1; bus.load_val = 3'd4; bus.load_dir = 1'b1;
    cycle("t3_load");
    chk("t3_load_val", 32'(bus.count), 32'd4);
    bus.load = 1'b0; bus.step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("t3");
      chk("t3_seq", 32'(bus.count), 32'(exp3[i]));
      chk("t3_dir", 32'(bus.dir), 32'd1);
    end

    // load wins over a simultaneous step
    set_cfg(0, 7, 0);
    bus.load = 1'b1; bus.load_val = 3'd6; bus.load_dir = 1'b1;
    cycle("t4_load");
    chk("t4_load_count", 32'(bus.count), 32'd6);
    bus.load = 1'b0;
    cycle("t4_step");
    chk("t4_step_count", 32'(bus.count), 32'd5);

    // inverted bounds freeze the counter
    set_cfg(5, 3, 0);
    for (int i = 0; i < 3; i++) cycle("t5_err");
    chk("t5_frozen", 32'(bus.count), 32'd5);
    bus.step = 1'b0; bus.load = 1'b1; bus.load_val = '0; bus.load_dir = 1'b0;
    cycle("t5_load");
    bus.load = 1'b0; bus.step = 1'b1;
    set_cfg(5, 6, 0);
    cycle("t5_fix");
    chk("t5_fix_count", 32'(bus.count), 32'd5);
    chk("t5_fix_hit",   32'(bus.hit),   32'd1);

    // asynchronous reset mid-sweep, step kept high during reset
    set_cfg(0, 7, 0);
    for (int i = 0; i < 3; i++) cycle("t6_pre");
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_count", 32'(bus.count), 32'(RVAL));
    chk("t6_async_dir",   32'(bus.dir),   32'd0);
    chk("t6_async_hit",   32'(bus.hit),   32'd0);
    m_c = RVAL; m_d = 0; m_h = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("t6_held_count", 32'(bus.count), 32'(RVAL));
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t6_post");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.step = ($urandom_range(3) != 0);
      bus.load = ($urandom_range(15) == 0);
      bus.load_val = W'($urandom);
      bus.load_dir = 1'($urandom);
      if ($urandom_range(15) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(7) == 0) begin
        bus.lo = W'($urandom);
        bus.hi = W'($urandom);
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
